// File: rtl/player_health.sv
// Per-player hit-point tracker with multi-point damage and heal, revive, and a post-hit
// invulnerability window. Outputs are the hp count, a thermometer life bar and status flags.
module player_health #(
   parameter int MAX_LIFE      = 10,
   parameter int DMG_W         = 4,
   parameter int INVULN_CYCLES = 8,
   localparam int HP_W         = $clog2(MAX_LIFE + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                damage,
   input  logic [DMG_W-1:0]    damage_amt,
   input  logic                heal,
   input  logic [DMG_W-1:0]    heal_amt,
   input  logic                revive,
   output logic [HP_W-1:0]     hp,
   output logic [MAX_LIFE-1:0] life,
   output logic                invuln,
   output logic                dead,
   output logic                hit_pulse
);

   localparam logic [1:0] ST_ALIVE  = 2'd0;
   localparam logic [1:0] ST_INVULN = 2'd1;
   localparam logic [1:0] ST_DEAD   = 2'd2;

   // Two guard bits keep hp + heal - damage free of wrap-around before the clamp.
   localparam int AW    = ((HP_W > DMG_W) ? HP_W : DMG_W) + 2;
   localparam int CNT_W = (INVULN_CYCLES < 1) ? 1 : $clog2(INVULN_CYCLES + 1);

   logic [1:0]       state, state_d;
   logic [HP_W-1:0]  hp_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             hit_ok, heal_ok;
   logic [AW-1:0]    sum;
   logic [HP_W-1:0]  clamped;

   assign hit_ok  = damage && (damage_amt != '0) && (state == ST_ALIVE);
   assign heal_ok = heal && (state != ST_DEAD);

   // Heal and damage are netted in one step so a simultaneous pair cannot kill then heal.
   assign sum = AW'(hp) + (heal_ok ? AW'(heal_amt) : '0) - (hit_ok ? AW'(damage_amt) : '0);

   always_comb begin
      if (sum[AW-1])
         clamped = '0;
      else if (sum > AW'(MAX_LIFE))
         clamped = HP_W'(MAX_LIFE);
      else
         clamped = HP_W'(sum);
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_d = state;
      hp_d    = hp;
      cnt_d   = cnt;
      case (state)
         ST_ALIVE: begin
            hp_d = clamped;
            if (hit_ok) begin
               if (clamped == '0) begin
                  state_d = ST_DEAD;
               end else if (INVULN_CYCLES != 0) begin
                  state_d = ST_INVULN;
                  cnt_d   = CNT_W'(INVULN_CYCLES);
               end
            end
         end
         ST_INVULN: begin
            hp_d  = clamped;
            cnt_d = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
               state_d = ST_ALIVE;
         end
         ST_DEAD: begin
            if (revive) begin
               hp_d    = HP_W'(MAX_LIFE);
               state_d = ST_ALIVE;
            end
         end
         default: state_d = ST_ALIVE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ALIVE;
         hp        <= HP_W'(MAX_LIFE);
         cnt       <= '0;
         hit_pulse <= 1'b0;
      end else begin
         state     <= state_d;
         hp        <= hp_d;
         cnt       <= cnt_d;
         hit_pulse <= hit_ok;
      end
   end

   assign invuln = (state == ST_INVULN);
   assign dead   = (state == ST_DEAD);

   for (genvar i = 0; i < MAX_LIFE; i++) begin : g_bar
      assign life[i] = (HP_W'(i) < hp);
   end

endmodule

// File: doc/player_health.md
# player_health

Parametrised player life tracker: the successor to the fixed 10-step life register. It accepts multi-point damage, healing and revive requests, and enforces an invulnerability window after every accepted hit. It exposes the current hit-point count, a thermometer-coded life bar for the LED/display driver, and status flags for the game-control FSM. There is one instance per player, clocked in the game clock domain.

## Interface
- MAX_LIFE, 10, maximum hit points; legal range 1..1023; also the width of the life bar.
- DMG_W, 4, width of damage_amt and heal_amt.
- INVULN_CYCLES, 8, length of the post-hit invulnerability window in clock cycles; 0 disables the window.
- HP_W, derived as $clog2(MAX_LIFE+1), width of hp; not to be overridden.

Ports:
- clk  in  1  game clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- damage  in  1  damage request, sampled every cycle.
- damage_amt  in  DMG_W  hit points removed when damage is accepted.
- heal  in  1  heal request, sampled every cycle.
- heal_amt  in  DMG_W  hit points added when heal is accepted.
- revive  in  1  restore a dead player to full life.
- hp  out  HP_W  current hit points, registered.
- life  out  MAX_LIFE  thermometer bar: bit i = (i < hp).
- invuln  out  1  high while state = INVULN.
- dead  out  1  high while state = DEAD.
- hit_pulse  out  1  one-cycle registered pulse for each accepted hit.

## Operation
- The FSM has three states: ALIVE, INVULN, DEAD.
- Reset (rst_n low, asynchronous):
  - hp = MAX_LIFE, so life is all ones.
  - state = ALIVE; invuln = 0, dead = 0, hit_pulse = 0.
  - Invulnerability counter = 0.
- A hit is accepted when damage = 1, damage_amt != 0 and state = ALIVE.
- A heal is accepted when heal = 1 and state != DEAD. heal_amt = 0 is accepted and has no effect.
- hp update arithmetic:
  - Computed in max(HP_W, DMG_W)+2 bits.
  - next = hp + (heal accepted ? heal_amt : 0) − (hit accepted ? damage_amt : 0).
  - The result is clamped to the range 0..MAX_LIFE.
  - Both requests in the same cycle are netted in a single step. Applying them sequentially is not allowed.
- ALIVE transitions:
  - Accepted hit with next = 0: go to DEAD, hp = 0.
  - Accepted hit with next > 0: go to INVULN, load the counter with INVULN_CYCLES. If INVULN_CYCLES = 0, stay in ALIVE.
  - Otherwise: stay in ALIVE, applying any heal.
- INVULN transitions:
  - damage is ignored entirely; no hit_pulse is produced.
  - Heal is applied normally.
  - The counter decrements every cycle. When the counter = 1, go to ALIVE.
- DEAD transitions:
  - damage and heal are ignored.
  - revive = 1: hp = MAX_LIFE, go to ALIVE.
  - revive is ignored in ALIVE and INVULN.
- hit_pulse is asserted in the cycle after an accepted hit, including a killing hit.
- life is decoded combinationally from the hp register.

## Timing
- Inputs are sampled at a rising edge of clk. hp, state and flags reflect the result immediately after that edge, giving 1-cycle latency.
- The invuln window length:
  - invuln is high for exactly INVULN_CYCLES cycles, starting the cycle after the hit.
  - damage presented in the cycle that invuln falls is accepted.
  - That cycle is the first cycle in ALIVE.
- Held damage with INVULN_CYCLES = N produces one hit every N+1 cycles.
- A killing hit never raises invuln.
- Reset asserted mid-window or mid-death takes effect immediately and asynchronously. The state machine resumes in ALIVE with full life on the first edge after rst_n rises.
- A heal that saturates at MAX_LIFE is not an error; no flag is raised.

## Test plan
Defaults for all scenarios: MAX_LIFE=10, DMG_W=4, INVULN_CYCLES=4.
- Reset: drive rst_n=0 mid-run → hp=10, life=10'h3FF, invuln=0, dead=0, hit_pulse=0 without waiting for a clock edge.
- Single hit: damage=1, damage_amt=3 for 1 cycle at hp=10 → hp=7, life=10'h07F, hit_pulse high for 1 cycle, invuln high for exactly 4 cycles. A damage_amt=5 pulse during the window leaves hp=7.
- Held damage: damage=1, damage_amt=1 held for 12 cycles from hp=10 → hp steps 9, 8, 7 at 5-cycle intervals, with three hit_pulses.
- Simultaneous events at hp=7 in ALIVE: damage_amt=4 with heal_amt=6 → hp=9, invuln=1. Then heal_amt=15 → hp=10 (saturated).
- Overkill and revive: at hp=2, damage_amt=15 → hp=0, dead=1, life=0, invuln=0, hit_pulse=1. heal_amt=5 while dead → hp stays 0. revive=1 → hp=10, dead=0.
- Zero damage and reset mid-window:
  - damage=1, damage_amt=0 → hp unchanged, no hit_pulse, no invuln.
  - rst_n low during INVULN at hp=6 → hp=10, invuln=0 immediately.
  - Parameter sweep with MAX_LIFE=1, INVULN_CYCLES=0: any nonzero hit → dead.
